// File: rtl/n64_frame_rx_if.sv
// n64_frame_rx_if: controller line in, decoded frame strobes out.
// Ports: n64_i (raw line), data_o/valid_o/err_o/busy_o (frame results).
// master = receiver side, slave = pad driver / frame consumer side.
interface n64_frame_rx_if #(
    parameter int FRAME_BITS = 32
);
    logic                  n64_i;
    logic [FRAME_BITS-1:0] data_o;
    logic                  valid_o;
    logic                  err_o;
    logic                  busy_o;

    modport master (
        input  n64_i,
        output data_o,
        output valid_o,
        output err_o,
        output busy_o
    );

    modport slave (
        output n64_i,
        input  data_o,
        input  valid_o,
        input  err_o,
        input  busy_o
    );
endinterface

// File: rtl/n64_frame_rx.sv
// n64_frame_rx: pulse-width decoder for the N64 controller data line.
// Ports: clk_i, rst_ni (async active-low), bus (n64_frame_rx_if.master):
//   n64_i raw line, data_o last good frame (first bit in MSB),
//   valid_o/err_o one-cycle strobes, busy_o frame in progress.
// Optional: define N64_RX_GLITCH_FILTER_EN for a 3-sample line filter.
module n64_frame_rx #(
    parameter int CLKS_PER_US = 14,
    parameter int FRAME_BITS  = 32,
    parameter int TIMEOUT_US  = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    n64_frame_rx_if.master   bus
);
    localparam int T_BIT = 2 * CLKS_PER_US;
    localparam int T_MAX = 4 * CLKS_PER_US;
    localparam int T_OUT = TIMEOUT_US * CLKS_PER_US;
    localparam int CW    = $clog2(T_OUT + 1);
    localparam int BW    = $clog2(FRAME_BITS + 2);

    localparam logic [CW-1:0] T_BIT_C = CW'(T_BIT);
    localparam logic [CW-1:0] T_MAX_C = CW'(T_MAX);
    localparam logic [CW-1:0] T_OUT_C = CW'(T_OUT);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [BW-1:0] BC_END  = BW'(FRAME_BITS + 1);
    localparam logic [BW-1:0] BC_MAX  = BW'(FRAME_BITS + 2);

    typedef enum logic [1:0] {
        ARM,
        IDLE,
        LOW,
        HIGH
    } state_t;

    logic s1_q, s2_q;
    logic s;
    logic sp_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= bus.n64_i;
            s2_q <= s1_q;
        end
    end

`ifdef N64_RX_GLITCH_FILTER_EN
    // s follows the line only once three consecutive samples agree.
    logic f1_q, f2_q, flt_q;

    always_comb begin
        s = flt_q;
        if (s2_q == f1_q && f1_q == f2_q) begin
            s = s2_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            f1_q  <= 1'b1;
            f2_q  <= 1'b1;
            flt_q <= 1'b1;
        end else begin
            f1_q  <= s2_q;
            f2_q  <= f1_q;
            flt_q <= s;
        end
    end
`else
    assign s = s2_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp_q <= 1'b1;
        end else begin
            sp_q <= s;
        end
    end

    logic fall, rise;
    assign fall = sp_q & ~s;
    assign rise = ~sp_q & s;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
    logic [BW-1:0]         bc_q, bc_d, bc_inc;
    logic [FRAME_BITS:0]   sr_q, sr_d;
    logic [FRAME_BITS-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    assign cnt_inc = (cnt_q == T_OUT_C) ? cnt_q : cnt_q + ONE_C;
    assign bc_inc  = (bc_q == BC_MAX) ? bc_q : bc_q + BW'(1);

    // The edge cycle itself counts as the first sample of the new level,
    // so on a rising edge cnt_q equals the number of low samples seen.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        bc_d    = bc_q;
        sr_d    = sr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ARM: begin
                if (!s) begin
                    cnt_d = '0;
                end else if (cnt_q == T_OUT_C) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (fall) begin
                    state_d = LOW;
                    cnt_d   = ONE_C;
                    bc_d    = '0;
                end
            end
            LOW: begin
                if (rise && cnt_q <= T_MAX_C) begin
                    sr_d    = {sr_q[FRAME_BITS-1:0], cnt_q < T_BIT_C};
                    bc_d    = bc_inc;
                    cnt_d   = ONE_C;
                    state_d = HIGH;
                end else if (!s && cnt_q >= T_MAX_C) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ARM;
                end
            end
            HIGH: begin
                if (fall) begin
                    cnt_d   = ONE_C;
                    state_d = LOW;
                end else if (cnt_q == T_OUT_C) begin
                    if (bc_q == BC_END) begin
                        data_d  = sr_q[FRAME_BITS:1];
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = ARM;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARM;
            cnt_q   <= '0;
            bc_q    <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bc_q    <= bc_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
    assign bus.err_o   = err_q;
    assign bus.busy_o  = (state_q == LOW) || (state_q == HIGH);
endmodule

// File: doc/n64_frame_rx.md
# n64_frame_rx

Parametrised N64 controller-line receiver: it decodes the one-wire, pulse-width-coded response on the controller data line into a parallel frame. A `FRAME_BITS`-bit payload word is captured with a one-cycle valid strobe, and malformed frames are flagged. It replaces the divided-clock stub receiver. All timing is derived from a per-microsecond cycle count instead of a slowed clock, and it sits between the pad input and the button-mapping logic.

## Interface
- `CLKS_PER_US`, 14, system clock cycles per microsecond (14 MHz internal oscillator).
- `FRAME_BITS`, 32, payload bits per frame, excluding the stop bit.
- `TIMEOUT_US`, 8, line-high time in µs that ends a frame or arms the receiver.
- `clk_i`  input  1  system clock; all logic on the rising edge.
- `rst_ni`  input  1  asynchronous active-low reset.
- `n64_i`  input  1  raw controller data line; asynchronous; idle high.
- `data_o`  output  FRAME_BITS  last good frame, first-received bit in MSB; reset 0.
- `valid_o`  output  1  one-cycle pulse when `data_o` updates; reset 0.
- `err_o`  output  1  one-cycle pulse on a malformed frame; reset 0.
- `busy_o`  output  1  high while a frame is in progress (LOW/HIGH states); reset 0.

## Operation
- `n64_i` passes through a 2-flop synchroniser; both flops reset to 1. Edges are detected on the synchronised value `s`.
- Constants:
  - `T_BIT = 2*CLKS_PER_US` (28)
  - `T_MAX = 4*CLKS_PER_US` (56)
  - `T_OUT = TIMEOUT_US*CLKS_PER_US` (112)
- The counter is `$clog2(T_OUT+1)` bits wide and saturates; it never wraps.
- The bit counter is `$clog2(FRAME_BITS+2)` bits wide and saturates at `FRAME_BITS+2`.
- States:
  - **ARM** (reset state): counts cycles with `s`=1; `s`=0 clears the count. On count == `T_OUT`, go to IDLE.
  - **IDLE**: on a falling edge of `s`, go to LOW; clear the counter and bit count.
  - **LOW**: counts cycles.
    - On a rising edge, if the counter ≤ `T_MAX`: bit = (counter < `T_BIT`), i.e. a short low is 1 and a long low is 0. Shift the bit into the shift register, increment the bit count, clear the counter, go to HIGH.
    - If the counter reaches `T_MAX+1` while still low: pulse `err_o`, go to ARM.
  - **HIGH**: counts cycles.
    - On a falling edge: go to LOW with the counter cleared.
    - On count == `T_OUT`:
      - If bit count == `FRAME_BITS+1`: load `data_o` from the first `FRAME_BITS` received bits (the stop bit is discarded) and pulse `valid_o`.
      - Otherwise pulse `err_o`, covering both short and long frames.
      - Either way, go to IDLE.
- `valid_o` and `err_o` are never high in the same cycle.
- `data_o` is unchanged on error.
- Reset mid-frame: all state returns to ARM and the partial frame is dropped. Frames cannot be captured until the line has been high for `T_OUT`.

## Timing
- Input-to-decision latency: 2 cycles for the synchroniser (+2 with the filter enabled).
- `valid_o`/`err_o` assert on the cycle after the HIGH counter reaches `T_OUT`, i.e. `T_OUT+1` cycles after the last rising edge (plus synchroniser latency).
- Bit-decision boundary: a low of exactly `T_BIT-1` cycles decodes as 1; `T_BIT` cycles decodes as 0.
- Minimum accepted low is 1 cycle; there is no lower bound check.
- Back-to-back frames are accepted: IDLE responds to a falling edge on the cycle after the strobe.

## Configuration
- `N64_RX_GLITCH_FILTER_EN` defined: a 3-sample filter sits after the synchroniser. `s` changes only after 3 consecutive equal synchronised samples, and the filter resets to 1. This adds 2 cycles of latency, and pulses of ≤2 cycles are ignored.
- Not defined: `s` is the synchroniser output directly, and every 1-cycle pulse is a valid edge.

## Test plan
- Release reset with the line high for 112 cycles, then send 32 bits of 0x80000000 plus a stop bit (1 µs low = 1, 3 µs low = 0), then 112 cycles high. Expect `valid_o` for one cycle and `data_o`=0x80000000.
- Send the same frame with only 31 bits plus stop. Expect one `err_o` pulse, no `valid_o`, and `data_o` holding its previous value.
- Send a frame with one low lasting 57 cycles. Expect `err_o` at low cycle 57 and then ARM. A valid frame sent after 112 idle cycles is decoded correctly.
- Boundary decoding: a low of 27 cycles decodes as bit 1; a low of 28 cycles decodes as bit 0. Check the bit in `data_o` of a full frame.
- Assert `rst_ni` mid-frame at bit 10, release it with the line low, then drive a 112-cycle high followed by frame 0x12345678. Expect exactly one `valid_o`, with `data_o`=0x12345678.
- With `N64_RX_GLITCH_FILTER_EN`, inject 2-cycle low spikes during HIGH. Expect no extra bits and a correct frame. Without the macro, expect `err_o`.
